// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences lw/sw/R-type/beq/addi/j and drives
// ALU control, datapath mux selects and write enables with MemReady stalls.
module mips_mc_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               ALU_zero,
  input  logic               MemReady,
  output logic [2:0]         ALU_Control,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 'd0,
    DECODE  = 'd1,
    MEMADR  = 'd2,
    MEMRD   = 'd3,
    MEMWB   = 'd4,
    MEMWR   = 'd5,
    EXECUTE = 'd6,
    ALUWB   = 'd7,
    BRANCH  = 'd8,
    ADDIEX  = 'd9,
    ADDIWB  = 'd10,
    JUMP    = 'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state, next_state;
  logic   is_load, next_is_load;
  logic   pc_write, branch;
  logic   ir_write, mem_write, reg_write, illegal;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default:                                               funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100010: alu_of_funct = 3'b110;
      6'b100100: alu_of_funct = 3'b000;
      6'b100101: alu_of_funct = 3'b001;
      6'b101010: alu_of_funct = 3'b111;
      default:   alu_of_funct = 3'b010;
    endcase
  endfunction

  // lw/sw choice is latched in DECODE so MEMADR never has to look at Op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      is_load <= 1'b0;
    end else begin
      state   <= next_state;
      is_load <= next_is_load;
    end
  end

  always_comb begin
    next_state   = state;
    next_is_load = is_load;
    ALU_Control  = 3'b010;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSrc        = 2'b00;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    ir_write     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    illegal      = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        ir_write = MemReady;
        pc_write = MemReady;
        if (MemReady) next_state = DECODE;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        next_state = FETCH;
        case (Op)
          OP_LW, OP_SW: begin
            next_state   = MEMADR;
            next_is_load = (Op == OP_LW);
          end
          OP_RTYPE: begin
            if (funct_ok(Funct)) next_state = EXECUTE;
            else                 illegal    = 1'b1;
          end
          OP_BEQ:  next_state = BRANCH;
          OP_ADDI: next_state = ADDIEX;
          OP_J:    next_state = JUMP;
          default: illegal    = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = is_load ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (MemReady) next_state = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        IorD      = 1'b1;
        mem_write = MemReady;
        if (MemReady) next_state = FETCH;
      end
      EXECUTE: begin
        ALUSrcA     = 1'b1;
        ALU_Control = alu_of_funct(Funct);
        next_state  = ALUWB;
      end
      ALUWB: begin
        RegDst     = 1'b1;
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALU_Control = 3'b110;
        PCSrc       = 2'b01;
        branch      = 1'b1;
        next_state  = FETCH;
      end
      ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  // Strobes are gated by rst_n so nothing is written once reset falls mid-cycle
  assign PCEn     = rst_n & (pc_write | (branch & ALU_zero));
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;
  assign Illegal  = rst_n & illegal;
  assign State    = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle expected output vectors are
// queued at drive time and popped/asserted at the negedge sample point.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Funct;
  logic       ALU_zero, MemReady;
  logic [2:0] ALU_Control;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       PCEn, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, Illegal;
  logic [3:0] State;

  mips_mc_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .ALU_zero(ALU_zero),
    .MemReady(MemReady), .ALU_Control(ALU_Control), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .IorD(IorD),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       pcen, iord, irw, memw, regdst, m2r, regw, ill;
  } outv_t;

  outv_t sb[$];
  string tags[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic outv_t ex(input logic [3:0] st);
    outv_t v = '0;
    v.st  = st;
    v.alu = 3'b010;
    return v;
  endfunction

  function automatic outv_t e_fetch(input logic mr);
    outv_t v = ex(4'd0); v.srcb = 2'b01; v.irw = mr; v.pcen = mr; return v;
  endfunction
  function automatic outv_t e_dec(input logic ill);
    outv_t v = ex(4'd1); v.srcb = 2'b11; v.ill = ill; return v;
  endfunction
  function automatic outv_t e_memadr();
    outv_t v = ex(4'd2); v.srca = 1'b1; v.srcb = 2'b10; return v;
  endfunction
  function automatic outv_t e_memrd();
    outv_t v = ex(4'd3); v.iord = 1'b1; return v;
  endfunction
  function automatic outv_t e_memwb();
    outv_t v = ex(4'd4); v.m2r = 1'b1; v.regw = 1'b1; return v;
  endfunction
  function automatic outv_t e_memwr(input logic mr);
    outv_t v = ex(4'd5); v.iord = 1'b1; v.memw = mr; return v;
  endfunction
  function automatic outv_t e_exec(input logic [2:0] alu);
    outv_t v = ex(4'd6); v.srca = 1'b1; v.alu = alu; return v;
  endfunction
  function automatic outv_t e_aluwb();
    outv_t v = ex(4'd7); v.regdst = 1'b1; v.regw = 1'b1; return v;
  endfunction
  function automatic outv_t e_br(input logic z);
    outv_t v = ex(4'd8); v.srca = 1'b1; v.alu = 3'b110; v.pcsrc = 2'b01; v.pcen = z; return v;
  endfunction
  function automatic outv_t e_addiex();
    outv_t v = ex(4'd9); v.srca = 1'b1; v.srcb = 2'b10; return v;
  endfunction
  function automatic outv_t e_addiwb();
    outv_t v = ex(4'd10); v.regw = 1'b1; return v;
  endfunction
  function automatic outv_t e_jump();
    outv_t v = ex(4'd11); v.pcsrc = 2'b10; v.pcen = 1'b1; return v;
  endfunction

  // Sample current outputs and compare against the oldest queued expectation.
  task automatic chk(input outv_t e, input string tag);
    outv_t got, exp_v;
    string t;
    sb.push_back(e);
    tags.push_back(tag);
    #1;
    got = {State, ALU_Control, ALUSrcA, ALUSrcB, PCSrc, PCEn, IorD, IRWrite,
           MemWrite, RegDst, MemtoReg, RegWrite, Illegal};
    exp_v = sb.pop_front();
    t     = tags.pop_front();
    vectors++;
    assert (got === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (state obs=%0d exp=%0d)",
             t, got, exp_v, got.st, exp_v.st);
    end
  endtask

  task automatic cyc(input logic mr, input logic z, input outv_t e, input string tag);
    @(negedge clk);
    MemReady = mr;
    ALU_zero = z;
    chk(e, tag);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    Op = op;
    Funct = fn;
  endtask

  logic [5:0] rfun [4];
  logic [2:0] ralu [4];

  initial begin
    rfun = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    ralu = '{3'b110, 3'b000, 3'b001, 3'b111};
    rst_n = 1'b0; MemReady = 1'b1; ALU_zero = 1'b0;
    set_ir(6'b000000, 6'b100000);
    #2;
    chk(e_fetch(1'b0), "reset_gated");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add
    chk(e_fetch(1'b1), "add_fetch");
    cyc(1, 0, e_dec(0), "add_decode");
    cyc(1, 0, e_exec(3'b010), "add_exec");
    cyc(1, 0, e_aluwb(), "add_wb");

    // remaining R-type functs; MemReady low in EXECUTE must be ignored
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, e_fetch(1), "r_fetch");
      set_ir(6'b000000, rfun[i]);
      cyc(1, 0, e_dec(0), "r_decode");
      cyc(0, 0, e_exec(ralu[i]), "r_exec");
      cyc(1, 0, e_aluwb(), "r_wb");
    end

    // lw with two MemReady-low cycles in MEMRD
    cyc(1, 0, e_fetch(1), "lw_fetch");
    set_ir(6'b100011, 6'b000000);
    cyc(1, 0, e_dec(0), "lw_decode");
    cyc(1, 0, e_memadr(), "lw_memadr");
    cyc(0, 0, e_memrd(), "lw_memrd_stall1");
    cyc(0, 0, e_memrd(), "lw_memrd_stall2");
    cyc(1, 0, e_memrd(), "lw_memrd_go");
    cyc(1, 0, e_memwb(), "lw_memwb");

    // beq taken, preceded by a fetch stall
    cyc(0, 0, e_fetch(0), "beq_fetch_stall");
    cyc(1, 0, e_fetch(1), "beq_fetch");
    set_ir(6'b000100, 6'b000000);
    cyc(1, 1, e_dec(0), "beq_decode");
    cyc(1, 1, e_br(1), "beq_taken");
    cyc(1, 0, e_fetch(1), "beq2_fetch");
    cyc(1, 0, e_dec(0), "beq2_decode");
    cyc(1, 0, e_br(0), "beq_not_taken");

    // sw with three MemReady-low cycles in MEMWR
    cyc(1, 0, e_fetch(1), "sw_fetch");
    set_ir(6'b101011, 6'b000000);
    cyc(1, 0, e_dec(0), "sw_decode");
    cyc(1, 0, e_memadr(), "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(0, 0, e_memwr(0), "sw_stall");
    cyc(1, 0, e_memwr(1), "sw_write");

    // addi
    cyc(1, 0, e_fetch(1), "addi_fetch");
    set_ir(6'b001000, 6'b000000);
    cyc(1, 0, e_dec(0), "addi_decode");
    cyc(1, 0, e_addiex(), "addi_ex");
    cyc(1, 0, e_addiwb(), "addi_wb");

    // j
    cyc(1, 0, e_fetch(1), "j_fetch");
    set_ir(6'b000010, 6'b000000);
    cyc(1, 0, e_dec(0), "j_decode");
    cyc(1, 0, e_jump(), "j_jump");

    // illegal opcode, then illegal funct
    cyc(1, 0, e_fetch(1), "ill_op_fetch");
    set_ir(6'b111111, 6'b100000);
    cyc(1, 0, e_dec(1), "ill_op_decode");
    cyc(1, 0, e_fetch(1), "ill_fn_fetch");
    set_ir(6'b000000, 6'b000111);
    cyc(1, 0, e_dec(1), "ill_fn_decode");

    // reset asserted during ALUWB
    cyc(1, 0, e_fetch(1), "rst_fetch");
    set_ir(6'b000000, 6'b100000);
    cyc(1, 0, e_dec(0), "rst_decode");
    cyc(1, 0, e_exec(3'b010), "rst_exec");
    cyc(1, 0, e_aluwb(), "rst_aluwb");
    #1;
    rst_n = 1'b0;
    chk(e_fetch(0), "rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    chk(e_fetch(1), "rst_resume_fetch");
    cyc(1, 0, e_dec(0), "rst_resume_decode");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
